// File: rtl/addecrc.sv
// Appends an IEEE 802.3 CRC-32 FCS to a nibble stream (LS nibble of each byte first).
// One i_ce-cycle registered latency; i_ce low stalls everything; there is no backpressure path.
module addecrc (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ce,
  input  logic       i_en,
  input  logic       i_cancel,
  input  logic       i_v,
  input  logic [3:0] i_d,
  output logic       o_v,
  output logic [3:0] o_d
);

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    NOCRC = 2'd2,
    CRC   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ov_q, ov_d;
  logic [3:0]  od_q, od_d;

  // Four serial reflected-CRC steps, data bit 0 first.
  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 4; k++) begin
      r = (r >> 1) ^ (((r[0] ^ d[k]) == 1'b1) ? CRC_POLY : 32'h0);
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    od_d    = od_q;
    if (i_ce) begin
      if (i_cancel) begin
        ov_d    = 1'b0;
        od_d    = 4'h0;
        state_d = IDLE;
        crc_d   = CRC_INIT;
        cnt_d   = 3'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (i_v) begin
              ov_d    = 1'b1;
              od_d    = i_d;
              crc_d   = crc_nib(CRC_INIT, i_d);
              state_d = i_en ? DATA : NOCRC;
            end else begin
              ov_d = 1'b0;
              od_d = 4'h0;
            end
          end
          DATA: begin
            ov_d = 1'b1;
            if (i_v) begin
              od_d  = i_d;
              crc_d = crc_nib(crc_q, i_d);
            end else begin
              // First FCS nibble goes out right behind the last data nibble.
              od_d    = ~crc_q[3:0];
              crc_d   = {4'hF, crc_q[31:4]};
              cnt_d   = 3'd1;
              state_d = CRC;
            end
          end
          CRC: begin
            ov_d  = 1'b1;
            od_d  = ~crc_q[3:0];
            crc_d = {4'hF, crc_q[31:4]};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_d = IDLE;
              crc_d   = CRC_INIT;
              cnt_d   = 3'd0;
            end
          end
          NOCRC: begin
            ov_d = i_v;
            od_d = i_d;
            if (!i_v) begin
              state_d = IDLE;
              crc_d   = CRC_INIT;
            end
          end
          default: begin
            state_d = IDLE;
            crc_d   = CRC_INIT;
            cnt_d   = 3'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      crc_q   <= CRC_INIT;
      cnt_q   <= 3'd0;
      ov_q    <= 1'b0;
      od_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
    end
  end

  assign o_v = ov_q;
  assign o_d = od_q;

endmodule
